regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
//   Multi-ported integer register file with a per-register pending-write scoreboard.
//   It serves pipelined or dual-issue RISC-V cores: NRD read ports, NWR write ports,
//   optional same-cycle write-to-read bypass, and a registered count of pending registers.
//   It sits between decode/issue (reads, pending marks) and writeback (writes, pending clears).
// PARAMETERS
//   XLEN    32  data width of each register
//   NREGS   32  register count; power of 2, >= 2; AW = $clog2(NREGS)
//   NRD      2  number of read ports, >= 1
//   NWR      2  number of write ports, >= 1
//   BYPASS   1  1 = a read sees same-cycle write data; 0 = a read sees the stored value
// PORTS
//   clk        in   1           rising-edge clock
//   res        in   1           synchronous active-high reset
//   wr_en      in   NWR         per-port write enable
//   wr_addr    in   NWR*AW      write addresses; port p is at [p*AW +: AW]
//   wr_data    in   NWR*XLEN    write data; port p is at [p*XLEN +: XLEN]
//   rd_addr    in   NRD*AW      read addresses; port r is at [r*AW +: AW]
//   rd_data    out  NRD*XLEN    read data, combinational
//   rd_busy    out  NRD         1 = the addressed register has an outstanding write
//   iss_en     in   1           mark iss_addr as pending (the instruction is issued)
//   iss_addr   in   AW          destination register of the issued instruction
//   busy_cnt   out  AW+1        registered count of pending registers
// BEHAVIOUR
//   - Clock and reset: one clock, clk. Reset res is synchronous and active-high, sampled on the rising edge of clk.
//   - Reset: all registers <= 0, all pending bits <= 0, busy_cnt <= 0.
//     While res is high, writes and issues are ignored.
//     After reset: rd_data = 0 and rd_busy = 0 for every address.
//     Reset mid-operation drops all pending state; no write is retired in that cycle.
//   - Register 0: always reads 0, is never busy, and ignores writes and issues.
//   - Writes: take effect at the rising edge when wr_en[p]=1 and wr_addr[p]!=0.
//     If several ports write the same address in one cycle, the highest port index wins.
//     No error is flagged.
//   - Reads: combinational from the stored array; latency is 0 cycles.
//     With BYPASS=1, a read address matching an active write port (addr!=0) returns
//     that port's wr_data this cycle. The highest matching port index wins.
//     With BYPASS=0, the new value is visible from the cycle after the edge.
//   - Scoreboard: pend[NREGS-1:0].
//     Set: iss_en=1 and iss_addr!=0 sets pend[iss_addr] at the edge.
//     Clear: any active write to address a clears pend[a] at the edge.
//     Set and clear of the same address in one cycle: set wins, and the data is still written.
//     Writes to non-pending registers are legal and leave pend unchanged.
//   - rd_busy[r] = pend[rd_addr[r]] && !(BYPASS && an active write targets rd_addr[r] this cycle).
//     rd_busy is 0 for address 0.
//   - busy_cnt equals the population count of pend after the edge.
//     It is updated incrementally: +1 per newly set bit, -1 per newly cleared bit.
//     Range is 0..NREGS-1 and it never wraps.
// TESTING
//   1. Reset, then read every address on all ports -> rd_data=0, rd_busy=0, busy_cnt=0.
//   2. Port 0 writes x5=0xDEADBEEF. Next cycle, read rd_addr0=5 -> 0xDEADBEEF.
//      Port 1 writes x0=0x1234 -> x0 still reads 0.
//   3. Same cycle, port 0 writes x7=0x11 and port 1 writes x7=0x22 -> x7 reads 0x22 afterwards.
//      With BYPASS=1 and a same-cycle read of x7 -> 0x22. With BYPASS=0 -> the old value.
//   4. Issue x3, x4, x5 on consecutive cycles -> busy_cnt = 1, 2, 3 and rd_busy set for each.
//      Then write x4 -> busy_cnt=2 and x4 not busy. With BYPASS=1, a same-cycle read of x4 shows busy=0.
//   5. Same cycle: iss_en with iss_addr=6 while x6 is pending and is also written
//      -> x6 is updated, stays pending, and busy_cnt is unchanged.
//   6. Pend x1..x4, then assert res mid-stream together with a write to x2
//      -> all regs read 0, busy_cnt=0, and the write is dropped.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-ported register file with a per-register pending-write scoreboard and pending count.
// Latency: reads and rd_busy are combinational (0 cycles); writes, pend and busy_cnt update at the edge.
// Backpressure: none; every write and issue presented is accepted in the cycle it is presented.
module regfile_mp_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                res,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_set;
    logic [NREGS-1:0] pend_clr;
    logic [NREGS-1:0] pend_nxt;
    logic [NWR-1:0]   wr_act;
    logic [AW:0]      cnt_inc;
    logic [AW:0]      cnt_dec;

    // A write is live only for a non-zero address outside reset; x0 stays hardwired to zero.
    always_comb begin
        wr_act = '0;
        for (int p = 0; p < NWR; p++) begin
            wr_act[p] = wr_en[p] && (wr_addr[p*AW +: AW] != '0) && !res;
        end
    end

    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        cnt_dec  = '0;
        for (int p = 0; p < NWR; p++) begin
            if (wr_act[p]) begin
                pend_clr[wr_addr[p*AW +: AW]] = 1'b1;
            end
        end
        if (iss_en && (iss_addr != '0) && !res) begin
            pend_set[iss_addr] = 1'b1;
        end
        // A set of the same address overrides its clear in the same cycle.
        pend_nxt = (pend & ~pend_clr) | pend_set;
        cnt_inc  = {{AW{1'b0}}, |(pend_set & ~pend)};
        for (int i = 0; i < NREGS; i++) begin
            cnt_dec = cnt_dec + {{AW{1'b0}}, pend[i] & pend_clr[i] & ~pend_set[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pend     <= '0;
            busy_cnt <= '0;
        end else begin
            // Later ports are assigned last, so the highest port index wins on a collision.
            for (int p = 0; p < NWR; p++) begin
                if (wr_act[p]) begin
                    regs[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
                end
            end
            pend     <= pend_nxt;
            busy_cnt <= busy_cnt + cnt_inc - cnt_dec;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int r = 0; r < NRD; r++) begin
            rd_data[r*XLEN +: XLEN] = regs[rd_addr[r*AW +: AW]];
            rd_busy[r]              = pend[rd_addr[r*AW +: AW]];
            if (BYPASS != 0) begin
                for (int p = 0; p < NWR; p++) begin
                    if (wr_act[p] && (wr_addr[p*AW +: AW] == rd_addr[r*AW +: AW])) begin
                        rd_data[r*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
                        rd_busy[r]              = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: a bypassing instance and a non-bypassing instance share one stimulus.
`timescale 1ns/1ps
module tb_regfile_mp_sb;

    logic        clk;
    logic        res;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [9:0]  rd_addr;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [5:0]  busy_cnt;
    logic [63:0] nb_rd_data;
    logic [1:0]  nb_rd_busy;
    logic [5:0]  nb_busy_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;
    exp_t sb[$];

    regfile_mp_sb #(.BYPASS(1)) dut (
        .clk(clk), .res(res), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt)
    );

    regfile_mp_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .res(res), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(nb_busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Kinds: 0/1 rd_data port0/1, 2/3 rd_busy port0/1, 4 busy_cnt, 5/6/7 same for the BYPASS=0 copy.
    function automatic logic [31:0] observe(input int kind);
        case (kind)
            0:       return rd_data[31:0];
            1:       return rd_data[63:32];
            2:       return 32'(rd_busy[0]);
            3:       return 32'(rd_busy[1]);
            4:       return 32'(busy_cnt);
            5:       return nb_rd_data[31:0];
            6:       return 32'(nb_rd_busy[0]);
            default: return 32'(nb_busy_cnt);
        endcase
    endfunction

    task automatic push(input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        res     = 1'b0;
        wr_en   = '0;
        iss_en  = 1'b0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wr_en[p]          = 1'b1;
        wr_addr[p*5 +: 5] = a;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic iss(input logic [4:0] a);
        iss_en   = 1'b1;
        iss_addr = a;
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [31:0] o;
        idle();
        wr_addr = '0; wr_data = '0; iss_addr = '0; rd_addr = '0;
        res = 1'b1;
        cyc();
        cyc();
        res = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            push(0, 32'h0, "reset_rd0");
            push(1, 32'h0, "reset_rd1");
            push(2, 32'h0, "reset_busy0");
            push(3, 32'h0, "reset_busy1");
            if (a == 0) push(4, 32'h0, "reset_cnt");
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                o = observe(e.kind);
                checks++;
                if (o !== e.val) begin
                    errors++;
                    $display("FAIL %s addr=%0d: got %h expected %h", e.name, a, o, e.val);
                end
            end
            cyc();
        end
    endtask

    task automatic test_write();
        exp_t        e;
        logic [31:0] o;
        for (int s = 0; s < 2; s++) begin
            idle();
            case (s)
                0: begin
                    wr(0, 5'd5, 32'hDEADBEEF);
                    wr(1, 5'd0, 32'h1234);
                    rd_addr = {5'd0, 5'd5};
                    push(0, 32'hDEADBEEF, "write_bypass_x5");
                    push(5, 32'h0, "write_nobypass_old_x5");
                    push(1, 32'h0, "write_x0_bypass_blocked");
                end
                default: begin
                    rd_addr = {5'd0, 5'd5};
                    push(0, 32'hDEADBEEF, "write_x5_stored");
                    push(5, 32'hDEADBEEF, "write_nobypass_x5_stored");
                    push(1, 32'h0, "write_x0_reads_zero");
                    push(3, 32'h0, "write_x0_not_busy");
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                o = observe(e.kind);
                checks++;
                if (o !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, o, e.val);
                end
            end
            cyc();
        end
    endtask

    task automatic test_same_addr();
        exp_t        e;
        logic [31:0] o;
        for (int s = 0; s < 2; s++) begin
            idle();
            rd_addr = {5'd7, 5'd7};
            if (s == 0) begin
                wr(0, 5'd7, 32'h11);
                wr(1, 5'd7, 32'h22);
                push(0, 32'h22, "same_addr_bypass_rd0");
                push(1, 32'h22, "same_addr_bypass_rd1");
                push(5, 32'h0, "same_addr_nobypass_old");
            end else begin
                push(0, 32'h22, "same_addr_stored");
                push(5, 32'h22, "same_addr_nobypass_stored");
            end
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                o = observe(e.kind);
                checks++;
                if (o !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, o, e.val);
                end
            end
            cyc();
        end
    endtask

    task automatic test_scoreboard();
        exp_t        e;
        logic [31:0] o;
        for (int s = 0; s < 6; s++) begin
            idle();
            case (s)
                0: begin
                    iss(5'd3);
                    rd_addr = {5'd0, 5'd3};
                    push(4, 32'd0, "sb_cnt0");
                    push(2, 32'd0, "sb_x3_not_yet_busy");
                end
                1: begin
                    iss(5'd4);
                    rd_addr = {5'd0, 5'd3};
                    push(4, 32'd1, "sb_cnt1");
                    push(2, 32'd1, "sb_x3_busy");
                    push(3, 32'd0, "sb_x0_never_busy");
                end
                2: begin
                    iss(5'd5);
                    rd_addr = {5'd4, 5'd3};
                    push(4, 32'd2, "sb_cnt2");
                    push(2, 32'd1, "sb_x3_busy2");
                    push(3, 32'd1, "sb_x4_busy");
                end
                3: begin
                    rd_addr = {5'd5, 5'd4};
                    push(4, 32'd3, "sb_cnt3");
                    push(2, 32'd1, "sb_x4_busy2");
                    push(3, 32'd1, "sb_x5_busy");
                end
                4: begin
                    wr(0, 5'd4, 32'h44);
                    rd_addr = {5'd5, 5'd4};
                    push(0, 32'h44, "sb_x4_bypass_data");
                    push(2, 32'd0, "sb_x4_bypass_not_busy");
                    push(6, 32'd1, "sb_x4_nobypass_busy");
                    push(3, 32'd1, "sb_x5_still_busy");
                    push(4, 32'd3, "sb_cnt_before_clear");
                end
                default: begin
                    rd_addr = {5'd5, 5'd4};
                    push(4, 32'd2, "sb_cnt_after_clear");
                    push(2, 32'd0, "sb_x4_cleared");
                    push(6, 32'd0, "sb_x4_cleared_nobypass");
                    push(0, 32'h44, "sb_x4_stored");
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                o = observe(e.kind);
                checks++;
                if (o !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, o, e.val);
                end
            end
            cyc();
        end
    endtask

    task automatic test_set_clear();
        exp_t        e;
        logic [31:0] o;
        for (int s = 0; s < 6; s++) begin
            idle();
            case (s)
                0: begin
                    iss(5'd6);
                    rd_addr = {5'd6, 5'd6};
                    push(4, 32'd2, "sc_cnt_start");
                end
                1: begin
                    iss(5'd6);
                    wr(1, 5'd6, 32'h66);
                    rd_addr = {5'd6, 5'd6};
                    push(4, 32'd3, "sc_cnt_x6_pending");
                    push(0, 32'h66, "sc_x6_bypass");
                    push(2, 32'd0, "sc_x6_bypass_not_busy");
                    push(6, 32'd1, "sc_x6_nobypass_busy");
                end
                2: begin
                    rd_addr = {5'd6, 5'd6};
                    push(0, 32'h66, "sc_x6_written");
                    push(2, 32'd1, "sc_x6_still_pending");
                    push(4, 32'd3, "sc_cnt_unchanged");
                end
                3: begin
                    wr(0, 5'd3, 32'h33);
                    wr(1, 5'd5, 32'h55);
                    rd_addr = {5'd5, 5'd3};
                    push(4, 32'd3, "sc_cnt_before_dual_clear");
                end
                4: begin
                    wr(1, 5'd9, 32'h99);
                    rd_addr = {5'd9, 5'd5};
                    push(4, 32'd1, "sc_cnt_dual_clear");
                    push(2, 32'd0, "sc_x5_cleared");
                    push(0, 32'h55, "sc_x5_stored");
                end
                default: begin
                    rd_addr = {5'd9, 5'd3};
                    push(4, 32'd1, "sc_cnt_nonpending_write");
                    push(0, 32'h33, "sc_x3_stored");
                    push(1, 32'h99, "sc_x9_stored");
                    push(3, 32'd0, "sc_x9_not_busy");
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                o = observe(e.kind);
                checks++;
                if (o !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, o, e.val);
                end
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        exp_t        e;
        logic [31:0] o;
        for (int s = 0; s < 8; s++) begin
            idle();
            rd_addr = {5'd2, 5'd1};
            case (s)
                0, 1, 2, 3: iss(5'(s + 1));
                4: begin
                    push(4, 32'd5, "rm_cnt_before_reset");
                    push(2, 32'd1, "rm_x1_busy");
                    push(3, 32'd1, "rm_x2_busy");
                end
                5: begin
                    res = 1'b1;
                    wr(0, 5'd2, 32'hBAD);
                    iss(5'd7);
                end
                6: begin
                    rd_addr = {5'd6, 5'd2};
                    push(4, 32'd0, "rm_cnt_zero");
                    push(7, 32'd0, "rm_cnt_zero_nobypass");
                    push(0, 32'h0, "rm_x2_write_dropped");
                    push(2, 32'd0, "rm_x2_not_busy");
                    push(1, 32'h0, "rm_x6_cleared");
                    push(3, 32'd0, "rm_x6_not_busy");
                end
                default: begin
                    rd_addr = {5'd7, 5'd5};
                    push(0, 32'h0, "rm_x5_cleared");
                    push(3, 32'd0, "rm_x7_issue_dropped");
                    push(4, 32'd0, "rm_cnt_stays_zero");
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                o = observe(e.kind);
                checks++;
                if (o !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, o, e.val);
                end
            end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_same_addr();
        test_scoreboard();
        test_set_clear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
